// File: rtl/emu_io_pkg.sv
// Shared types and constants for the emulator host I/O bridge.
package emu_io_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SNAP = 2'd1,
    SEND = 2'd2
  } state_t;

  localparam int KEY_LSB = 20;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/emu_key_debounce.sv
// Per-key debouncer: a key level changes only after DEB_N consecutive
// differing samples, sampled on tick.
module emu_key_debounce
  import emu_io_pkg::*;
#(
  parameter int KEY_W = 4,
  parameter int DEB_N = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic [KEY_W-1:0] raw,
  output logic [KEY_W-1:0] key
);

  localparam int CNT_W = (DEB_N > 1) ? $clog2(DEB_N) : 1;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DEB_N - 1);

  logic [CNT_W-1:0] cnt_q [KEY_W];

  // NOTE: this counter array is a few flops, not a RAM, so it is reset like any other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key <= '1;
      for (int i = 0; i < KEY_W; i++) cnt_q[i] <= '0;
    end else if (tick) begin
      for (int i = 0; i < KEY_W; i++) begin
        if (raw[i] == key[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_TOP) begin
          key[i]   <= raw[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/emu_io_bridge.sv
// Host word interface <-> board I/O bridge: captures SW/KEY from host words and
// streams periodic LEDR/HEX snapshots. Optional macro: EMU_CHANGE_ONLY_EN.
module emu_io_bridge
  import emu_io_pkg::*;
#(
  parameter int WORD_W   = 31,
  parameter int LEDR_W   = 18,
  parameter int SW_W     = 18,
  parameter int KEY_W    = 4,
  parameter int NUM_HEX  = 8,
  parameter int HEX_W    = 8,
  parameter int TICK_DIV = 100000,
  parameter int DEB_N    = 4,
  localparam int PAY_W   = LEDR_W + NUM_HEX * HEX_W,
  localparam int NWORDS  = ceil_div(PAY_W, WORD_W),
  localparam int IDX_W   = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
  input  logic                     CLOCK_50,
  input  logic                     RESET_N,
  input  logic [WORD_W-1:0]        in_word,
  input  logic                     in_valid,
  output logic [SW_W-1:0]          SW,
  output logic [KEY_W-1:0]         KEY,
  input  logic [LEDR_W-1:0]        LEDR,
  input  logic [NUM_HEX*HEX_W-1:0] HEX,
  output logic [WORD_W-1:0]        out_word,
  output logic [IDX_W-1:0]         out_idx,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic [7:0]               drop_cnt
);

  localparam int FRAME_W = NWORDS * WORD_W;
  localparam int TICK_W  = $clog2(TICK_DIV);
  localparam logic [TICK_W-1:0] TICK_TOP = TICK_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NWORDS - 1);

  // Sample tick
  logic [TICK_W-1:0] tick_cnt_q;
  logic              tick;

  assign tick = (tick_cnt_q == TICK_TOP);

  // NOTE: every clocked process assigns state with <= so all flops update together at the edge.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N)  tick_cnt_q <= '0;
    else if (tick) tick_cnt_q <= '0;
    else           tick_cnt_q <= tick_cnt_q + TICK_W'(1);
  end

  // Input path: only the switch and key fields of the host word are kept
  logic [SW_W-1:0]  sw_q;
  logic [KEY_W-1:0] raw_key_q;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sw_q      <= '0;
      raw_key_q <= '0;
    end else if (in_valid) begin
      sw_q      <= in_word[SW_W-1:0];
      raw_key_q <= in_word[KEY_LSB +: KEY_W];
    end
  end

  assign SW = sw_q;

  emu_key_debounce #(
    .KEY_W (KEY_W),
    .DEB_N (DEB_N)
  ) u_debounce (
    .clk   (CLOCK_50),
    .rst_n (RESET_N),
    .tick  (tick),
    .raw   (raw_key_q),
    .key   (KEY)
  );

  // Output frame FSM
  state_t                        state_q, state_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic                          pend_q, pend_d;
  logic                          load_payload;
  logic [7:0]                    drop_q;
  logic [NWORDS-1:0][WORD_W-1:0] payload_q;
  logic [FRAME_W-1:0]            payload_new;

  assign payload_new = FRAME_W'({HEX, LEDR});

`ifdef EMU_CHANGE_ONLY_EN
  logic [FRAME_W-1:0] sent_q;
  logic               frame_done;

  assign frame_done = out_valid && out_ready && out_last;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N)        sent_q <= '0;
    else if (frame_done) sent_q <= payload_q;
  end
`endif

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    pend_d       = pend_q;
    load_payload = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick || pend_q) begin
          state_d = SNAP;
          pend_d  = 1'b0;
        end
      end
      SNAP: begin
        load_payload = 1'b1;
        idx_d        = '0;
        state_d      = SEND;
`ifdef EMU_CHANGE_ONLY_EN
        if (payload_new == sent_q) state_d = IDLE;
`endif
        if (tick) pend_d = 1'b1;
      end
      SEND: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) state_d = IDLE;
          else                   idx_d   = idx_q + IDX_W'(1);
        end
        if (tick) pend_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      pend_q    <= 1'b0;
      payload_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      if (load_payload) payload_q <= payload_new;
    end
  end

  // A tick that finds a snapshot already pending is lost
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N)                               drop_q <= '0;
    else if (tick && pend_q && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
  end

  assign out_valid = (state_q == SEND);
  assign out_idx   = idx_q;
  assign out_word  = payload_q[idx_q];
  assign out_last  = out_valid && (idx_q == LAST_IDX);
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_emu_io_bridge.sv
// Directed bench for emu_io_bridge: one instance with a 16-cycle tick for
// framing/debounce and one with a 4-cycle tick for drop counting.
module tb_emu_io_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [30:0] in_word;
  logic        in_valid;
  logic [17:0] ledr;
  logic [63:0] hex;
  logic        ready_a, ready_b;

  logic [17:0] sw_a, sw_b;
  logic [3:0]  key_a, key_b;
  logic [30:0] word_a, word_b;
  logic [1:0]  idx_a, idx_b;
  logic        valid_a, valid_b, last_a, last_b;
  logic [7:0]  drop_a, drop_b;

  int checks   = 0;
  int failures = 0;
  int cyc;

  always #10 clk = ~clk;

  // Posedges since reset release; both instances' tick counters follow this
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  emu_io_bridge #(.TICK_DIV(16), .DEB_N(4)) dut_a (
    .CLOCK_50 (clk),     .RESET_N  (rst_n),
    .in_word  (in_word), .in_valid (in_valid),
    .SW       (sw_a),    .KEY      (key_a),
    .LEDR     (ledr),    .HEX      (hex),
    .out_word (word_a),  .out_idx  (idx_a),
    .out_valid(valid_a), .out_ready(ready_a),
    .out_last (last_a),  .drop_cnt (drop_a)
  );

  emu_io_bridge #(.TICK_DIV(4), .DEB_N(4)) dut_b (
    .CLOCK_50 (clk),     .RESET_N  (rst_n),
    .in_word  (in_word), .in_valid (in_valid),
    .SW       (sw_b),    .KEY      (key_b),
    .LEDR     (ledr),    .HEX      (hex),
    .out_word (word_b),  .out_idx  (idx_b),
    .out_valid(valid_b), .out_ready(ready_b),
    .out_last (last_b),  .drop_cnt (drop_b)
  );

  typedef struct {
    logic        vld;
    logic [30:0] word;
    logic [17:0] sw;
    logic [3:0]  key;
  } cap_vec_t;

  typedef struct {
    logic [17:0] ledr;
    logic [63:0] hex;
    logic [30:0] w0;
    logic [30:0] w1;
    logic [30:0] w2;
  } frame_vec_t;

  cap_vec_t   cap_tbl [6];
  frame_vec_t frm     [3];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_valid_a(input logic lvl, input string name);
    int n = 0;
    while (valid_a !== lvl && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (valid_a !== lvl) begin
      checks++;
      failures++;
      $display("FAIL %s: timeout waiting for out_valid=%0b", name, lvl);
    end
  endtask

  task automatic wait_mod(input int m);
    do @(negedge clk); while ((cyc % 16) != m);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic load_word(input logic [30:0] w);
    in_word  = w;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input frame_vec_t f);
    ledr = f.ledr;
    hex  = f.hex;
    wait_valid_a(1'b0, "frame_idle");
    wait_valid_a(1'b1, "frame_start");
    check("tick_to_valid_phase", cyc % 16, 1);
    check("w0", word_a, f.w0);
    check("idx0", idx_a, 0);
    check("last_on_idx0", last_a, 0);
    @(negedge clk);
    check("w1", word_a, f.w1);
    check("idx1", idx_a, 1);
    check("last_on_idx1", last_a, 0);
    @(negedge clk);
    check("w2", word_a, f.w2);
    check("idx2", idx_a, 2);
    check("last_on_idx2", last_a, 1);
    @(negedge clk);
    check("valid_after_frame", valid_a, 0);
  endtask

  // Stall word 1 for 'hold' cycles, then expect 'gap' idle cycles before the next frame
  task automatic run_backpressure(input frame_vec_t f, input int hold, input int gap);
    int n;
    ledr = f.ledr;
    hex  = f.hex;
    wait_valid_a(1'b0, "bp_idle");
    wait_valid_a(1'b1, "bp_start");
    check("bp_w0", word_a, f.w0);
    @(negedge clk);
    ready_a = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("bp_hold_word", word_a, f.w1);
      check("bp_hold_idx", idx_a, 1);
      check("bp_hold_valid", valid_a, 1);
    end
    ready_a = 1'b1;
    @(negedge clk);
    check("bp_w2", word_a, f.w2);
    check("bp_last", last_a, 1);
    @(negedge clk);
    n = 0;
    while (!valid_a && n < 40) begin
      n++;
      @(negedge clk);
    end
`ifndef EMU_CHANGE_ONLY_EN
    check("bp_gap_to_next_frame", n, gap);
    check("bp_next_idx", idx_a, 0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    cap_tbl[0] = '{1'b1, 31'h00F2_1234, 18'h21234, 4'hF};
    cap_tbl[1] = '{1'b0, 31'h0001_2345, 18'h21234, 4'hF};
    cap_tbl[2] = '{1'b1, 31'h7FFF_FFFF, 18'h3FFFF, 4'hF};
    cap_tbl[3] = '{1'b1, 31'h00FA_AAAA, 18'h2AAAA, 4'hF};
    cap_tbl[4] = '{1'b1, 31'h00F1_5555, 18'h15555, 4'hF};
    cap_tbl[5] = '{1'b1, 31'h00F0_0000, 18'h00000, 4'hF};

    frm[0] = '{18'h2AAAA, 64'h8877_6655_4433_2211, 31'h0846_AAAA, 31'h32AA_2199, 31'h0008_8776};
    frm[1] = '{18'h3FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 31'h7FFF_FFFF, 31'h7FFF_FFFF, 31'h000F_FFFF};
    frm[2] = '{18'h00001, 64'h0,                   31'h0000_0001, 31'h0000_0000, 31'h0000_0000};

    rst_n    = 1'b0;
    in_word  = 31'h00F0_0000;
    in_valid = 1'b1;
    ledr     = frm[0].ledr;
    hex      = frm[0].hex;
    ready_a  = 1'b1;
    ready_b  = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_sw", sw_a, 0);
    check("rst_key", key_a, 4'hF);
    check("rst_valid", valid_a, 0);
    check("rst_last", last_a, 0);
    check("rst_word", word_a, 0);
    check("rst_idx", idx_a, 0);
    check("rst_drop", drop_b, 0);

    rst_n = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;

    for (int i = 0; i < 6; i++) begin
      in_word  = cap_tbl[i].word;
      in_valid = cap_tbl[i].vld;
      @(negedge clk);
      in_valid = 1'b0;
      check($sformatf("cap_sw[%0d]", i), sw_a, cap_tbl[i].sw);
      check($sformatf("cap_key[%0d]", i), key_a, cap_tbl[i].key);
    end

    for (int i = 0; i < 3; i++) run_frame(frm[i]);

    run_backpressure(frm[0], 10, 3);
    // Completing handshake coincides with a tick: pend carries it through IDLE, SNAP
    run_backpressure(frm[1], 12, 2);

    wait_mod(1);
    load_word(31'h00E0_0000);
    repeat (3) wait_mod(0);
    check("deb_3ticks_key", key_a, 4'hF);
    load_word(31'h00F0_0000);
    repeat (2) wait_mod(0);
    check("deb_glitch_rejected", key_a, 4'hF);
    load_word(31'h00E0_0000);
    repeat (3) wait_mod(0);
    check("deb_hold_3ticks", key_a, 4'hF);
    wait_mod(15);
    check("deb_before_4th", key_a, 4'hF);
    wait_mod(0);
    check("deb_at_4th", key_a, 4'hE);
    load_word(31'h00F0_0000);
    repeat (3) wait_mod(0);
    check("deb_release_3ticks", key_a, 4'hE);
    wait_mod(0);
    check("deb_release_4th", key_a, 4'hF);

    run_frame(frm[2]);
`ifdef EMU_CHANGE_ONLY_EN
    begin
      bit seen = 1'b0;
      repeat (40) begin
        @(negedge clk);
        if (valid_a) seen = 1'b1;
      end
      check("chg_no_frame_when_same", seen, 0);
      ledr = ledr ^ 18'h1;
      wait_valid_a(1'b1, "chg_frame_on_toggle");
      check("chg_toggle_w0", word_a, 0);
      check("chg_toggle_idx", idx_a, 0);
    end
`else
    wait_valid_a(1'b1, "repeat_frame");
    check("repeat_frame_phase", cyc % 16, 1);
    check("repeat_frame_w0", word_a, 1);
`endif

    ledr = frm[0].ledr;
    hex  = frm[0].hex;
    wait_valid_a(1'b0, "mid_rst_idle");
    wait_valid_a(1'b1, "mid_rst_start");
    @(negedge clk);
    check("mid_rst_pos", idx_a, 1);
    #2;
    rst_n   = 1'b0;
    ready_b = 1'b0;
    #1;
    check("mid_rst_valid", valid_a, 0);
    check("mid_rst_idx", idx_a, 0);
    check("mid_rst_word", word_a, 0);
    check("mid_rst_last", last_a, 0);
    check("mid_rst_key", key_a, 4'hF);
    in_word  = 31'h00F0_0000;
    in_valid = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid_a(1'b1, "post_rst_frame");
    check("post_rst_first_valid_cyc", cyc, 17);
    check("post_rst_w0", word_a, frm[0].w0);

    wait_cyc(40);
    check("drop_at_40", drop_b, 8);
    check("drop_stall_valid", valid_b, 1);
    check("drop_stall_idx", idx_b, 0);
    wait_cyc(1020);
    check("drop_at_1020", drop_b, 253);
    wait_cyc(1028);
    check("drop_reaches_255", drop_b, 255);
    wait_cyc(1100);
    check("drop_saturated", drop_b, 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/emu_io_bridge.md
# emu_io_bridge

Synthesizable, parametrised bridge between the emulator host word interface and a user design's board I/O (switches, keys, LEDs, seven-segment digits). It captures host input words into stable `SW`/`KEY` levels, debouncing keys, and periodically snapshots `LEDR`/`HEX*` into a frame of fixed-width words streamed to the host over a valid/ready handshake. It sits between the host transport and `usertop`, replacing the fixed three-word, unconditioned packing with configurable widths, frame length, rate and flow control.

## Interface
Parameters:
- `WORD_W`, 31, host word width.
- `LEDR_W`, 18, red LED count.
- `SW_W`, 18, switch count; `SW_W <= WORD_W`.
- `KEY_W`, 4, key count; `20 + KEY_W <= WORD_W`.
- `NUM_HEX`, 8, seven-segment digits.
- `HEX_W`, 8, bits per digit.
- `TICK_DIV`, 100000, clock cycles per sample tick; `>= 2`.
- `DEB_N`, 4, consecutive identical tick samples required to accept a key change; `>= 1`.

Derived: `PAY_W = LEDR_W + NUM_HEX*HEX_W`; `NWORDS = ceil(PAY_W/WORD_W)`, which is 3 at defaults.

Ports:
- `CLOCK_50` in 1: sole clock.
- `RESET_N` in 1: asynchronous, active-low reset.
- `in_word` in `WORD_W`: host input word.
- `in_valid` in 1: load `in_word`.
- `SW` out `SW_W`: switch levels.
- `KEY` out `KEY_W`: debounced keys, active-low.
- `LEDR` in `LEDR_W`: from user design.
- `HEX` in `NUM_HEX*HEX_W`: digit `i` is at bits `[i*HEX_W +: HEX_W]`.
- `out_word` out `WORD_W`: frame word.
- `out_idx` out `$clog2(NWORDS)`, minimum 1 bit: index of the word in the frame.
- `out_valid` out 1: word available.
- `out_ready` in 1: host accepts.
- `out_last` out 1: final word of the frame.
- `drop_cnt` out 8: saturating count of lost ticks.

## Operation
Input path:
- On `in_valid`, the block registers `in_word` into a shadow register.
- `SW` = shadow `[SW_W-1:0]`, updated the cycle after `in_valid`.
- Raw keys = shadow `[20 +: KEY_W]`.
- Debounce runs per key, counting only at ticks.
  - A sample equal to the current `KEY` bit clears that key's counter.
  - A differing sample increments the counter.
  - When the counter reaches `DEB_N`, `KEY` takes the raw value and the counter clears.

Tick generator:
- Free-running counter from 0 to `TICK_DIV-1`.
- `tick` pulses for 1 cycle when the counter equals `TICK_DIV-1`.

Output state machine:
- **IDLE**: on `tick`, or when `pend` is set, go to SNAP and clear `pend`.
- **SNAP**: latch `payload = {HEX, LEDR}` (LEDR in the LSBs), zero-extended to `NWORDS*WORD_W`. Set index to 0 and go to SEND.
- **SEND**:
  - `out_valid` = 1.
  - `out_word` = `payload[idx*WORD_W +: WORD_W]`.
  - `out_last` = (`idx == NWORDS-1`).
  - When `out_valid && out_ready`: if last, go to IDLE; else increment `idx`.
- `out_word`, `out_idx` and `out_last` stay stable while `out_valid` is high and `out_ready` is low.

Pending and drop handling:
- A `tick` in SNAP or SEND sets `pend`.
- A `tick` while `pend` is already set increments `drop_cnt`, saturating at 255.
- A tick arriving in the same cycle as a frame-completing handshake sets `pend`; the FSM then goes IDLE, then SNAP.

## Timing
Reset values:
- `SW` = 0, `KEY` = all ones, shadow = 0.
- `out_valid` = 0, `out_last` = 0, `out_word` = 0, `out_idx` = 0.
- `drop_cnt` = 0, `pend` = 0, tick counter = 0, state = IDLE.

Latencies:
- `tick` to first `out_valid` is 2 cycles.
- A frame with `out_ready` held high takes exactly `NWORDS` cycles in SEND.

Reset behaviour:
- Reset asserted mid-frame aborts the frame immediately, with no partial completion.
- After release, the first tick occurs `TICK_DIV` cycles later.

`in_valid` is independent of the output FSM; simultaneous events on both paths do not interact.

## Configuration
`EMU_CHANGE_ONLY_EN`:
- **Defined**: SNAP compares the new payload with the last transmitted payload (register reset to 0). If they are equal, the FSM returns to IDLE with no words sent. After a frame completes, the sent payload is stored.
- **Undefined**: every tick produces a frame, and the compare register is absent.

## Structure
- Package `emu_io_pkg` holds:
  - the state enum (`IDLE`, `SNAP`, `SEND`);
  - the key field offset constant `KEY_LSB = 20`;
  - a `ceil_div` function for `NWORDS`.
- Sub-module `emu_key_debounce` contains the per-key counter array (`KEY_W`, `DEB_N`, `tick`).

## Test plan
1. **Defaults, frame content**: set `LEDR = 18'h2AAAA`, `HEX0..7 = 8'h11..8'h88`, `out_ready = 1`. Expect 3 words per tick:
   - word 0 = `payload[30:0]`;
   - word 2 zero-padded above bit 81;
   - `out_last` high only on `idx = 2`.
2. **Backpressure**: hold `out_ready = 0` for 10 cycles during word 1. Expect `out_word` and `out_idx = 1` to stay stable; the frame completes after release.
3. **Drops**: with `TICK_DIV = 4` and `out_ready = 0` for 40 cycles, expect `pend` to be set and `drop_cnt` to count up. Drive it past 255 ticks and check it holds at 255.
4. **Debounce** (`DEB_N = 4`):
   - Drive `in_word[20] = 0` for 3 ticks, then back to 1: `KEY[0]` stays 1.
   - Hold it at 0 for 4 ticks: `KEY[0]` becomes 0 at the 4th tick.
5. **Input capture**: `in_word = 31'h00F2_1234` with a `in_valid` pulse. Expect `SW = 18'h21234` next cycle and `KEY = 4'hF` unchanged.
6. **`EMU_CHANGE_ONLY_EN`**:
   - Constant `LEDR`/`HEX` gives one frame, then none.
   - Toggling `LEDR[0]` produces the next frame.
   - Mid-frame `RESET_N` low drops `out_valid` immediately.
